// File: rtl/stm_axi_pkg.sv
// Shared types and helpers for the AXI4 frame-buffer writer.
// The command length field is sized for the largest legal burst (256 beats).
package stm_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned CMD_LEN_W = 9;

  typedef struct packed {
    logic [CMD_LEN_W-1:0] len;
    logic                 sof;
    logic                 eol;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } wr_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered occupancy count.
// Writes while full and reads while empty are ignored.
module sync_fifo
  import stm_axi_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (do_pop)  rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/stm_axi_frame_wr.sv
// Writes a wide pixel stream into rotating DDR frame buffers with AXI4 INCR bursts.
// Ingress cuts the stream into segments; one burst per segment, one burst in flight.
module stm_axi_frame_wr
  import stm_axi_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 512,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           BURST_LEN    = 16,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE   = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = 32'h0080_0000,
  parameter int unsigned           FRAME_NUM    = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tvld,
  output logic                    s_axis_trdy,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [((FRAME_NUM > 1) ? clog2(FRAME_NUM) : 1)-1:0] o_frame_idx,
  output logic                    o_line_done,
  output logic                    o_err
);

  localparam int unsigned           BYTES      = DATA_WIDTH / 8;
  localparam int unsigned           IDX_W      = (FRAME_NUM > 1) ? clog2(FRAME_NUM) : 1;
  localparam int unsigned           DFW        = DATA_WIDTH + BYTES;
  localparam int unsigned           CMDW       = $bits(cmd_t);
  localparam logic [CMD_LEN_W-1:0]  SEG_MAX    = CMD_LEN_W'(BURST_LEN);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(FRAME_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(BYTES);

  wr_state_e             state_q, state_d;
  logic [CMD_LEN_W-1:0]  seg_cnt_q, seg_cnt_d;
  logic                  seg_sof_q, seg_sof_d;
  logic [CMD_LEN_W-1:0]  beat_q, beat_d;
  cmd_t                  cur_q, cur_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  logic                  line_done_q, line_done_d;

  logic                  accept;
  logic                  seg_close;
  logic [CMD_LEN_W-1:0]  seg_cnt_inc;
  cmd_t                  cmd_in;
  cmd_t                  cmd_out;
  logic                  cmd_pop, cmd_full, cmd_empty;
  logic                  dat_pop, dat_full, dat_empty;
  logic [DFW-1:0]        dat_out;

  assign s_axis_trdy = !dat_full && !cmd_full;
  assign accept      = s_axis_tvld && s_axis_trdy;
  assign seg_cnt_inc = seg_cnt_q + CMD_LEN_W'(1);
  assign seg_close   = accept && (s_axis_tlast || (seg_cnt_inc == SEG_MAX));

  // The command goes in on the same edge as its final beat, so W never waits on it.
  always_comb begin
    cmd_in.len = seg_cnt_inc;
    cmd_in.sof = (seg_cnt_q == '0) ? s_axis_tuser : seg_sof_q;
    cmd_in.eol = s_axis_tlast;
  end

  sync_fifo #(.WIDTH(DFW), .DEPTH(2 * BURST_LEN)) u_dat_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .push_i  (accept),
    .wdata_i ({s_axis_tkeep, s_axis_tdata}),
    .pop_i   (dat_pop),
    .rdata_o (dat_out),
    .full_o  (dat_full),
    .empty_o (dat_empty)
  );

  sync_fifo #(.WIDTH(CMDW), .DEPTH(4)) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .push_i  (seg_close),
    .wdata_i (cmd_in),
    .pop_i   (cmd_pop),
    .rdata_o (cmd_out),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  always_comb begin
    state_d       = state_q;
    seg_cnt_d     = seg_cnt_q;
    seg_sof_d     = seg_sof_q;
    beat_d        = beat_q;
    cur_d         = cur_q;
    idx_d         = idx_q;
    addr_d        = addr_q;
    err_d         = err_q;
    line_done_d   = 1'b0;
    cmd_pop       = 1'b0;
    dat_pop       = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;

    // A tuser after the first beat of a segment is flagged but never moves the address.
    if (accept) begin
      seg_cnt_d = seg_close ? '0 : seg_cnt_inc;
      if (seg_cnt_q == '0) seg_sof_d = s_axis_tuser;
      else if (s_axis_tuser) err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!cmd_empty) begin
          cmd_pop = 1'b1;
          cur_d   = cmd_out;
          beat_d  = '0;
          if (cmd_out.sof) begin
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            addr_d = FRAME_BASE + ADDR_WIDTH'(idx_d) * FRAME_STRIDE;
          end
          state_d = ST_AW;
        end
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = !dat_empty;
        m_axi_wlast  = m_axi_wvalid && (beat_q == cur_q.len - CMD_LEN_W'(1));
        if (m_axi_wvalid && m_axi_wready) begin
          dat_pop = 1'b1;
          beat_d  = beat_q + CMD_LEN_W'(1);
          if (m_axi_wlast) state_d = ST_B;
        end
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp != AXI_RESP_OKAY) err_d = 1'b1;
          addr_d      = addr_q + ADDR_WIDTH'(cur_q.len) * BEAT_BYTES;
          line_done_d = cur_q.eol;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      seg_cnt_q   <= '0;
      seg_sof_q   <= 1'b0;
      beat_q      <= '0;
      cur_q       <= '0;
      idx_q       <= IDX_LAST;
      addr_q      <= FRAME_BASE;
      err_q       <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_cnt_q   <= seg_cnt_d;
      seg_sof_q   <= seg_sof_d;
      beat_q      <= beat_d;
      cur_q       <= cur_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      line_done_q <= line_done_d;
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'(cur_q.len - CMD_LEN_W'(1));
  assign m_axi_awsize  = 3'(clog2(BYTES));
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wdata   = dat_out[DATA_WIDTH-1:0];
  assign m_axi_wstrb   = dat_out[DFW-1:DATA_WIDTH];
  assign o_frame_idx   = idx_q;
  assign o_line_done   = line_done_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_stm_axi_frame_wr.sv
// Randomized bench for stm_axi_frame_wr: lines are split into expected bursts
// by a queue-based model and checked against a randomly stalling AXI slave.
module tb_stm_axi_frame_wr;

  localparam int          BL     = 16;
  localparam int          FN     = 3;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] STRIDE = 32'h0080_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tlast, s_axis_tuser, s_axis_tvld, s_axis_trdy;
  logic [31:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_awvalid, m_axi_awready;
  logic [511:0] m_axi_wdata;
  logic [63:0]  m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid, m_axi_bready;
  logic [1:0]   o_frame_idx;
  logic         o_line_done, o_err;

  always #5 clk = ~clk;

  stm_axi_frame_wr dut (
    .i_clk(clk), .i_rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tvld(s_axis_tvld), .s_axis_trdy(s_axis_trdy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .o_frame_idx(o_frame_idx), .o_line_done(o_line_done), .o_err(o_err)
  );

  typedef struct { logic [511:0] d; logic [63:0] k; logic l; } beat_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; logic eol; int frame; } aw_t;

  beat_t       wQ[$];
  aw_t         awQ[$];
  int          checks = 0, failures = 0;
  int          modelFrame = FN - 1;
  logic [31:0] modelAddr = BASE;
  logic        expErr = 1'b0;
  int          outstanding = 0, bPend = 0, bDelay = 0, bHsPrev = 0;
  int          ldExpect = 0, inflightEol = 0, bCount = 0, berrBurst = -1;
  int          holdW = 0, stallAll = 0, acceptedCnt = 0, stimBusy = 0;

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one beat at a negedge and holds it until the DUT is ready at a negedge.
  task automatic pushBeat(input logic [511:0] d, input logic [63:0] k, input logic last, input logic user);
    int guard = 0;
    @(negedge clk);
    s_axis_tvld = 1'b1; s_axis_tdata = d; s_axis_tkeep = k;
    s_axis_tlast = last; s_axis_tuser = user;
    while (!s_axis_trdy && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!s_axis_trdy) checkOutput("trdy_timeout", s_axis_trdy, 1);
    else acceptedCnt++;
  endtask

  // Sends one line and records the bursts it must produce: chunks of BL beats,
  // a SOF line starting in the next frame buffer, addresses advancing by bytes written.
  task automatic applyStimulus(input int n, input bit sof, input logic [63:0] keepLast, input int errBeat);
    logic [511:0] d;
    logic [63:0]  k;
    int           pos, clen;
    aw_t          a;
    beat_t        b;
    for (int i = 0; i < n; i++) begin
      pos  = i % BL;
      clen = (n - (i - pos) < BL) ? n - (i - pos) : BL;
      if (pos == 0) begin
        if (i == 0 && sof) begin
          modelFrame = (modelFrame + 1) % FN;
          modelAddr  = BASE + modelFrame * STRIDE;
        end
        a.addr = modelAddr; a.len = 8'(clen - 1); a.eol = (i + clen == n); a.frame = modelFrame;
        awQ.push_back(a);
        modelAddr = modelAddr + clen * 64;
      end
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
      k = (i == n - 1) ? keepLast : '1;
      b.d = d; b.k = k; b.l = (pos == clen - 1);
      wQ.push_back(b);
      if (i == errBeat) expErr = 1'b1;
      pushBeat(d, k, (i == n - 1), (i == 0 && sof) || (i == errBeat));
    end
    @(negedge clk);
    s_axis_tvld = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while ((awQ.size() != 0 || wQ.size() != 0 || outstanding != 0 || bPend != 0) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) checkOutput("drain_timeout", awQ.size() + wQ.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // AXI slave: new ready/valid values are driven at the negedge, then the handshakes
  // that the following posedge will see are scored against the expected queues.
  initial begin
    aw_t   ea;
    beat_t eb;
    int    lowAddr, nBeats;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (o_line_done || ldExpect != 0) checkOutput("line_done", o_line_done, ldExpect);
      ldExpect = 0;
      if (bHsPrev != 0) begin
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; bHsPrev = 0;
      end
      if (stallAll != 0) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      end else begin
        m_axi_awready = ($urandom_range(0, 3) != 0);
        m_axi_wready  = (holdW != 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
      if (bPend != 0 && !m_axi_bvalid) begin
        if (bDelay == 0) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = (bCount == berrBurst) ? 2'b10 : 2'b00;
        end else bDelay--;
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (awQ.size() == 0) checkOutput("aw_unexpected", m_axi_awvalid, 0);
        else begin
          ea = awQ.pop_front();
          checkOutput("aw_outstanding", outstanding, 0);
          checkOutput("awaddr", m_axi_awaddr, ea.addr);
          checkOutput("awlen", m_axi_awlen, ea.len);
          checkOutput("frame_idx", o_frame_idx, ea.frame);
          checkOutput("awsize", m_axi_awsize, 3'd6);
          checkOutput("awburst", m_axi_awburst, 2'b01);
          lowAddr = int'(m_axi_awaddr[11:0]);
          nBeats  = int'(m_axi_awlen) + 1;
          checkOutput("cross_4k", (lowAddr + nBeats * 64) > 4096, 0);
          inflightEol = ea.eol;
          outstanding = 1;
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        checkOutput("w_without_aw", outstanding, 1);
        if (wQ.size() == 0) checkOutput("w_unexpected", m_axi_wvalid, 0);
        else begin
          eb = wQ.pop_front();
          checkOutput("wdata", m_axi_wdata, eb.d);
          checkOutput("wstrb", m_axi_wstrb, eb.k);
          checkOutput("wlast", m_axi_wlast, eb.l);
        end
        if (m_axi_wlast) begin
          bPend = 1; bDelay = $urandom_range(0, 3);
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        if (m_axi_bresp != 2'b00) expErr = 1'b1;
        outstanding = 0; bPend = 0; bHsPrev = 1;
        ldExpect = inflightEol;
        bCount++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, guard, n;
    bit sof;
    rst = 1'b1;
    s_axis_tvld = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_awvalid", m_axi_awvalid, 0);
    checkOutput("rst_wvalid", m_axi_wvalid, 0);
    checkOutput("rst_bready", m_axi_bready, 0);
    checkOutput("rst_line_done", o_line_done, 0);
    checkOutput("rst_err", o_err, 0);
    checkOutput("rst_frame_idx", o_frame_idx, FN - 1);
    checkOutput("rst_trdy", s_axis_trdy, 1);
    rst = 1'b0;

    $display("[TB] single-burst SOF line, then a two-burst line");
    applyStimulus(16, 1, '1, -1);
    waitIdle();
    applyStimulus(20, 0, '1, -1);
    waitIdle();

    $display("[TB] frame rotation over four SOF lines");
    for (int f = 0; f < 4; f++) applyStimulus(3 + f, 1, '1, -1);
    waitIdle();

    $display("[TB] backpressure with partial last keep");
    stallAll = 1;
    base = acceptedCnt;
    stimBusy = 1;
    fork
      begin
        applyStimulus(40, 0, 64'h0000_0000_0000_00FF, -1);
        stimBusy = 0;
      end
    join_none
    guard = 0;
    while (s_axis_trdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("trdy_drop", s_axis_trdy, 0);
    checkOutput("buffered_beats", acceptedCnt - base, 32);
    repeat (10) @(negedge clk);
    checkOutput("trdy_held", s_axis_trdy, 0);
    checkOutput("buffered_held", acceptedCnt - base, 32);
    stallAll = 0;
    guard = 0;
    while (stimBusy != 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("stim_done", stimBusy, 0);
    waitIdle();

    $display("[TB] stray tuser inside a segment");
    checkOutput("err_clear", o_err, expErr);
    applyStimulus(8, 0, '1, 2);
    waitIdle();
    checkOutput("err_tuser", o_err, expErr);

    $display("[TB] reset during W phase");
    holdW = 1;
    applyStimulus(16, 1, '1, -1);
    guard = 0;
    while (awQ.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    checkOutput("in_w_phase", m_axi_wvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_awvalid", m_axi_awvalid, 0);
    checkOutput("mid_rst_wvalid", m_axi_wvalid, 0);
    checkOutput("mid_rst_trdy", s_axis_trdy, 1);
    checkOutput("mid_rst_err", o_err, 0);
    checkOutput("mid_rst_frame_idx", o_frame_idx, FN - 1);
    rst = 1'b0;
    wQ.delete(); awQ.delete();
    outstanding = 0; bPend = 0; ldExpect = 0;
    modelFrame = FN - 1; modelAddr = BASE; expErr = 1'b0;
    holdW = 0;
    applyStimulus(16, 1, '1, -1);
    waitIdle();

    $display("[TB] SLVERR response on one burst");
    berrBurst = bCount;
    applyStimulus(16, 0, '1, -1);
    applyStimulus(4, 0, '1, -1);
    waitIdle();
    berrBurst = -1;
    checkOutput("err_bresp", o_err, expErr);

    $display("[TB] random back-to-back lines");
    for (int r = 0; r < 8; r++) begin
      n   = $urandom_range(1, 40);
      sof = (r == 0) || ($urandom_range(0, 2) == 0);
      applyStimulus(n, sof, {$urandom, $urandom}, -1);
    end
    waitIdle();
    checkOutput("err_final", o_err, expErr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
